// File: rtl/ex_mem_pkg.sv
// Shared types and default widths for the EX/MEM boundary stage.
package ex_mem_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]     alu_out;
    logic [DATA_W_DEF-1:0]     store_data;
    logic [REG_ADDR_W_DEF-1:0] dest_reg;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
    logic                      mem_to_reg;
  } entry_t;

endpackage

// File: rtl/ex_mem_slot.sv
// Single-entry register with load and synchronous clear; clear wins over load.
module ex_mem_slot #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: 2-entry skid buffer (head + skid), branch resolution and redirect.
// Define EX_MEM_FWD_EN to drive the fwd_* outputs from the head entry.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_W-1:0]     ex_alu_out,
  input  logic                  ex_zero,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_dest_reg,
  input  logic [DATA_W-1:0]     ex_pc_plus4,
  input  logic [DATA_W-1:0]     ex_imm,
  input  logic                  ex_is_branch,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  flush,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [DATA_W-1:0]     mem_alu_out,
  output logic [DATA_W-1:0]     mem_store_data,
  output logic [REG_ADDR_W-1:0] mem_dest_reg,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_reg_write,
  output logic                  mem_mem_to_reg,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_target,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data
);

  localparam int unsigned EntryW = 2 * DATA_W + REG_ADDR_W + 4;

  state_e              state_q, state_d;
  logic                ex_ready_q, mem_valid_q;
  logic                branch_taken_q;
  logic [DATA_W-1:0]   branch_target_q;
  logic                accept, pop, enq, taken_d;
  logic                head_load, head_clear, skid_load, skid_clear;
  logic [EntryW-1:0]   ex_entry, head_d, head_q, skid_q;
  logic [DATA_W-1:0]   target_d;

  assign accept   = ex_valid & ex_ready_q & ~flush;
  assign pop      = mem_valid_q & mem_ready;
  // Branches are consumed here and never reach MEM.
  assign enq      = accept & ~ex_is_branch;
  assign taken_d  = accept & ex_is_branch & ex_zero;
  assign target_d = ex_pc_plus4 + (ex_imm << 2);

  assign ex_entry = {ex_alu_out, ex_store_data, ex_dest_reg,
                     ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg};

  always_comb begin
    state_d    = state_q;
    head_d     = ex_entry;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (enq) begin
          state_d   = StOne;
          head_load = 1'b1;
        end
      end
      StOne: begin
        if (enq && !pop) begin
          state_d   = StTwo;
          skid_load = 1'b1;
        end else if (enq && pop) begin
          head_load = 1'b1;
        end else if (pop) begin
          state_d    = StEmpty;
          head_clear = 1'b1;
        end
      end
      StTwo: begin
        if (pop) begin
          state_d    = StOne;
          head_d     = skid_q;
          head_load  = 1'b1;
          skid_clear = 1'b1;
        end
      end
      default: begin
        state_d    = StEmpty;
        head_clear = 1'b1;
        skid_clear = 1'b1;
      end
    endcase
    // Flush overrides everything; any same-cycle pop has already been taken by MEM.
    if (flush) begin
      state_d    = StEmpty;
      head_load  = 1'b0;
      skid_load  = 1'b0;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StEmpty;
      ex_ready_q      <= 1'b1;
      mem_valid_q     <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      state_q        <= state_d;
      ex_ready_q     <= (state_d != StTwo);
      mem_valid_q    <= (state_d != StEmpty);
      branch_taken_q <= taken_d;
      if (taken_d) begin
        branch_target_q <= target_d;
      end
    end
  end

  ex_mem_slot #(
    .W (EntryW)
  ) u_head (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (head_load),
    .clear   (head_clear),
    .d       (head_d),
    .q       (head_q)
  );

  ex_mem_slot #(
    .W (EntryW)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .d       (ex_entry),
    .q       (skid_q)
  );

  assign ex_ready      = ex_ready_q;
  assign mem_valid     = mem_valid_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;
  assign {mem_alu_out, mem_store_data, mem_dest_reg,
          mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg} = head_q;

`ifdef EX_MEM_FWD_EN
  assign fwd_valid = mem_valid_q & mem_reg_write & ~mem_mem_to_reg & (mem_dest_reg != '0);
  assign fwd_reg   = mem_dest_reg;
  assign fwd_data  = mem_alu_out;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: queue-based reference model plus directed literal checks.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_ready, ex_zero, ex_is_branch;
  logic [31:0] ex_alu_out, ex_store_data, ex_pc_plus4, ex_imm;
  logic [4:0]  ex_dest_reg;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic        flush, mem_valid, mem_ready;
  logic [31:0] mem_alu_out, mem_store_data;
  logic [4:0]  mem_dest_reg;
  logic        mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;

`ifdef EX_MEM_FWD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  entry_t      mq[$];
  logic        m_taken;
  logic [31:0] m_target;
  logic [31:0] pops[$];

  always #5 clk = ~clk;

  ex_mem_stage u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_alu_out     (ex_alu_out),
    .ex_zero        (ex_zero),
    .ex_store_data  (ex_store_data),
    .ex_dest_reg    (ex_dest_reg),
    .ex_pc_plus4    (ex_pc_plus4),
    .ex_imm         (ex_imm),
    .ex_is_branch   (ex_is_branch),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_alu_out    (mem_alu_out),
    .mem_store_data (mem_store_data),
    .mem_dest_reg   (mem_dest_reg),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .fwd_valid      (fwd_valid),
    .fwd_reg        (fwd_reg),
    .fwd_data       (fwd_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries; branches produce a pulse instead.
  always @(posedge clk or negedge reset_n) begin : model
    bit acc;
    entry_t e;
    if (!reset_n) begin
      mq.delete();
      m_taken  = 1'b0;
      m_target = '0;
    end else begin
      acc = ex_valid && (mq.size() < 2) && !flush;
      if (mq.size() > 0 && mem_ready) void'(mq.pop_front());
      if (flush) mq.delete();
      m_taken = acc && ex_is_branch && ex_zero;
      if (m_taken) m_target = ex_pc_plus4 + (ex_imm << 2);
      if (acc && !ex_is_branch) begin
        e.alu_out    = ex_alu_out;
        e.store_data = ex_store_data;
        e.dest_reg   = ex_dest_reg;
        e.mem_read   = ex_mem_read;
        e.mem_write  = ex_mem_write;
        e.reg_write  = ex_reg_write;
        e.mem_to_reg = ex_mem_to_reg;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : compare
    entry_t h;
    if (reset_n) begin
      check("ex_ready", ex_ready, mq.size() < 2);
      check("mem_valid", mem_valid, mq.size() > 0);
      check("branch_taken", branch_taken, m_taken);
      check("branch_target", branch_target, m_target);
      if (mq.size() > 0) begin
        h = mq[0];
        check("head", {mem_alu_out, mem_store_data, mem_dest_reg, mem_mem_read,
                       mem_mem_write, mem_reg_write, mem_mem_to_reg}, h);
        check("fwd_valid", fwd_valid,
              FwdOn && h.reg_write && !h.mem_to_reg && (h.dest_reg != 0));
        check("fwd_reg", fwd_reg, FwdOn ? h.dest_reg : 5'd0);
        check("fwd_data", fwd_data, FwdOn ? h.alu_out : 32'd0);
        if (mem_ready && mem_valid) pops.push_back(mem_alu_out);
      end else begin
        check("fwd_valid_empty", fwd_valid, 1'b0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_zero = 0; ex_is_branch = 0; ex_alu_out = 0; ex_store_data = 0;
    ex_dest_reg = 0; ex_pc_plus4 = 0; ex_imm = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_reg_write = 0; ex_mem_to_reg = 0; flush = 0;
  endtask

  task automatic op(input logic [31:0] alu, input logic [4:0] dest, input logic rw,
                    input logic m2r);
    idle();
    ex_valid = 1; ex_alu_out = alu; ex_store_data = alu ^ 32'hA5A5_0000;
    ex_dest_reg = dest; ex_reg_write = rw; ex_mem_to_reg = m2r; ex_mem_read = m2r;
  endtask

  task automatic br(input logic [31:0] pc4, input logic [31:0] imm, input logic z);
    idle();
    ex_valid = 1; ex_is_branch = 1; ex_pc_plus4 = pc4; ex_imm = imm; ex_zero = z;
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (!mem_valid) break;
      cyc();
    end
    check("drain_timeout", mem_valid, 1'b0);
  endtask

  initial begin
    reset_n = 0; mem_ready = 0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_ex_ready", ex_ready, 1'b1);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_branch_taken", branch_taken, 1'b0);
    check("rst_mem_alu_out", mem_alu_out, 32'd0);
    check("rst_branch_target", branch_target, 32'd0);
    check("rst_fwd", {fwd_valid, fwd_reg, fwd_data}, 38'd0);
    reset_n = 1;

    // Single ALU op
    cyc();
    mem_ready = 1;
    op(32'h5, 5'd8, 1, 0);
    cyc();
    idle();
    @(negedge clk);
    check("op_mem_valid", mem_valid, 1'b1);
    check("op_alu_out", mem_alu_out, 32'h5);
    check("op_dest", mem_dest_reg, 5'd8);
    check("op_ex_ready", ex_ready, 1'b1);
    cyc();

    // Backpressure: three ops, third held upstream
    mem_ready = 0;
    op(32'd1, 5'd1, 1, 0); cyc();
    op(32'd2, 5'd2, 1, 0); cyc();
    op(32'd3, 5'd3, 1, 0);
    @(negedge clk);
    check("bp_ex_ready", ex_ready, 1'b0);
    check("bp_head", mem_alu_out, 32'd1);
    cyc(); cyc();
    mem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      if (ex_ready) break;
      cyc();
    end
    check("bp_ready_timeout", ex_ready, 1'b1);
    cyc();
    idle();
    drain();
    check("pops_count", pops.size(), 4);
    if (pops.size() == 4) begin
      check("pop0", pops[0], 32'd5);
      check("pop1", pops[1], 32'd1);
      check("pop2", pops[2], 32'd2);
      check("pop3", pops[3], 32'd3);
    end

    // Taken / not-taken branches and target wrap
    br(32'h0040_0010, 32'hFFFF_FFFC, 1); cyc(); idle();
    @(negedge clk);
    check("beq_taken", branch_taken, 1'b1);
    check("beq_target", branch_target, 32'h0040_0000);
    check("beq_no_mem", mem_valid, 1'b0);
    cyc();
    check("beq_pulse_end", branch_taken, 1'b0);
    br(32'h0040_0010, 32'hFFFF_FFFC, 0); cyc(); idle();
    @(negedge clk);
    check("bne_not_taken", branch_taken, 1'b0);
    check("bne_target_hold", branch_target, 32'h0040_0000);
    br(32'hFFFF_FFFC, 32'd2, 1); cyc(); idle();
    @(negedge clk);
    check("wrap_target", branch_target, 32'h0000_0004);

    // Flush in TWO with incoming taken branch
    mem_ready = 0;
    op(32'd10, 5'd4, 1, 0); cyc();
    op(32'd11, 5'd5, 1, 0); cyc();
    br(32'h100, 32'h4, 1); flush = 1; cyc(); idle();
    @(negedge clk);
    check("flush2_mem_valid", mem_valid, 1'b0);
    check("flush2_ex_ready", ex_ready, 1'b1);
    check("flush2_taken", branch_taken, 1'b0);

    // Flush in ONE suppresses an accepted-looking branch
    op(32'd12, 5'd6, 1, 0); cyc();
    br(32'h200, 32'h8, 1); flush = 1; cyc(); idle();
    @(negedge clk);
    check("flush1_taken", branch_taken, 1'b0);
    check("flush1_mem_valid", mem_valid, 1'b0);

    // Forwarding
    op(32'h1234, 5'd9, 1, 0); cyc(); idle();
    @(negedge clk);
    check("fwd_alu_valid", fwd_valid, FwdOn);
    check("fwd_alu_reg", fwd_reg, FwdOn ? 5'd9 : 5'd0);
    check("fwd_alu_data", fwd_data, FwdOn ? 32'h1234 : 32'd0);
    flush = 1; cyc();
    op(32'h1234, 5'd9, 1, 1); cyc(); idle();
    @(negedge clk);
    check("fwd_load", fwd_valid, 1'b0);
    flush = 1; cyc();
    op(32'h1234, 5'd0, 1, 0); cyc(); idle();
    @(negedge clk);
    check("fwd_r0", fwd_valid, 1'b0);
    flush = 1; cyc(); idle();

    // Reset mid-operation clears entries and a live branch pulse
    mem_ready = 0;
    op(32'd20, 5'd7, 1, 0); cyc();
    br(32'h300, 32'h1, 1); cyc(); idle();
    reset_n = 0;
    #1;
    check("mid_rst_taken", branch_taken, 1'b0);
    check("mid_rst_mem_valid", mem_valid, 1'b0);
    check("mid_rst_ex_ready", ex_ready, 1'b1);
    #1;
    reset_n = 1;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM boundary stage of the MIPS datapath, directly downstream of the ALU.
- Registers the ALU result, zero flag, store data and control bits into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Resolves conditional branches from the ALU zero flag and produces a registered redirect (taken pulse + target) for fetch.
- Absorbs MEM-side backpressure without combinational ready paths back into EX.

Parameters:
DATA_W, 32, datapath width (ALU result, store data, PC)
REG_ADDR_W, 5, destination register index width

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX presents an instruction
ex_ready  out  1  stage can accept; registered, equals "skid slot empty"
ex_alu_out  in  DATA_W  ALU result
ex_zero  in  1  ALU condition flag (branch compare result)
ex_store_data  in  DATA_W  rt value for stores
ex_dest_reg  in  REG_ADDR_W  writeback register index
ex_pc_plus4  in  DATA_W  PC+4 of the instruction
ex_imm  in  DATA_W  sign-extended branch immediate (word offset)
ex_is_branch  in  1  conditional branch (beq/bne/bgtz/blez/bgez/bltz)
ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  in  1 each  control bits
flush  in  1  kill all held and incoming entries this cycle
mem_valid  out  1  head entry valid
mem_ready  in  1  MEM consumes head
mem_alu_out, mem_store_data  out  DATA_W  head entry fields
mem_dest_reg  out  REG_ADDR_W  head entry field
mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg  out  1 each  head control bits
branch_taken  out  1  one-cycle redirect pulse
branch_target  out  DATA_W  redirect address, valid while branch_taken=1
fwd_valid  out  1  forwarding available (optional feature)
fwd_reg  out  REG_ADDR_W  forwarding register index
fwd_data  out  DATA_W  forwarding value

Behaviour:
- Reset (reset_n=0, async): state EMPTY; ex_ready=1; mem_valid=0; branch_taken=0; all data/control outputs 0; fwd_* 0.
- Accept = ex_valid & ex_ready & !flush. Pop = mem_valid & mem_ready.
- States:
  - EMPTY: no entries.
  - ONE: head valid, skid empty.
  - TWO: head and skid valid; ex_ready=0.
- Transitions:
  - EMPTY, accept -> ONE; the entry lands in head.
  - ONE, accept & !pop -> TWO; the entry lands in skid.
  - ONE, accept & pop -> ONE; head is replaced by the new entry.
  - ONE, pop & !accept -> EMPTY.
  - TWO, pop -> ONE; skid moves to head. Accept is impossible in TWO.
- Latency: accepted entry visible on mem_* on the next cycle when the stage was EMPTY or ONE with pop.
- ex_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
- Branches:
  - Resolved at accept. When ex_is_branch=1, the entry is NOT enqueued, so it has no MEM effect.
  - Next cycle: branch_taken = ex_zero; branch_target = ex_pc_plus4 + (ex_imm << 2), modulo 2^DATA_W (wraps, no overflow flag).
  - branch_taken is high for exactly one cycle per taken branch; branch_target holds its last value otherwise.
- Branches are accepted even in TWO? No: they obey ex_ready like any instruction.
- Delay slot: no self-flush on taken branch. Fetch/decode drive flush for wrong-path instructions.
- flush: synchronous. Next state EMPTY, mem_valid=0 next cycle, incoming entry dropped, pending branch_taken for a same-cycle incoming branch suppressed. A branch_taken already registered (current cycle) still asserts.
- Simultaneous flush & pop: pop completes on current head, then the stage empties.
- mem_* outputs are stable while mem_valid=1 & mem_ready=0.
- Reset mid-operation discards all entries and any pending branch pulse immediately.

Optional Feature:
Macro EX_MEM_FWD_EN.
- Defined: fwd_valid = mem_valid & mem_reg_write & !mem_mem_to_reg & (mem_dest_reg != 0); fwd_reg = mem_dest_reg; fwd_data = mem_alu_out. All are combinational from the head.
- Undefined: fwd_valid, fwd_reg and fwd_data are tied to 0. No forwarding logic is instantiated.

Decomposition:
- Package ex_mem_pkg holds:
  - state enum (EMPTY, ONE, TWO);
  - entry struct (alu_out, store_data, dest_reg, mem_read, mem_write, reg_write, mem_to_reg);
  - constants DATA_W_DEF=32, REG_ADDR_W_DEF=5.
- One sub-module, ex_mem_slot: single-entry register with load/clear, instantiated twice (head, skid).
- Branch-target adder stays inline.

Test Plan:
- Reset then single ALU op: alu_out=0x0000_0005, reg_write=1, dest=8, mem_ready=1 -> mem_valid=1 next cycle with mem_alu_out=5, mem_dest_reg=8; ex_ready stays 1.
- Backpressure: mem_ready=0, three back-to-back valid ops (1, 2, 3) -> ex_ready=0 after the 2nd accept, op 3 held upstream; raise mem_ready -> outputs 1, 2, 3 in order, none lost or duplicated.
- Taken beq: ex_is_branch=1, ex_zero=1, pc_plus4=0x0040_0010, imm=0xFFFF_FFFC -> branch_taken=1 for one cycle, branch_target=0x0040_0000, mem_valid unaffected. Same branch with ex_zero=0 -> no pulse.
- Wrap: pc_plus4=0xFFFF_FFFC, imm=2 -> branch_target=0x0000_0004.
- Flush in TWO state with an incoming branch (zero=1) -> next cycle mem_valid=0, ex_ready=1, branch_taken=0.
- With EX_MEM_FWD_EN: head reg_write=1, mem_to_reg=0, dest=9, alu_out=0x1234 -> fwd_valid=1, fwd_reg=9, fwd_data=0x1234. With dest=0 or a load -> fwd_valid=0. Without the macro -> fwd_valid always 0.
